// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared encodings for the RV32I pipeline hazard logic
package riscv_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_tracker_sat_counter.sv
// rtl/hazard_tracker_sat_counter.sv - saturating event counter with synchronous active-low clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - forwarding, load-use stall, flush control and hazard counters
module hazard_tracker #(
  parameter int REG_AW = riscv_pipe_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              reg_writeE,
  input  logic [1:0]        result_srcE,
  input  logic              pc_srcE,
  output logic [1:0]        forward_aE,
  output logic [1:0]        forward_bE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [REG_AW-1:0] rdM,
  output logic              reg_writeM,
  output logic [REG_AW-1:0] rdW,
  output logic              reg_writeW,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import riscv_pipe_pkg::*;

  logic [1:0] result_srcM;
  logic       lwStall;

  // Shadow M/W stages: Execute never stalls, so these advance every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdM         <= '0;
      reg_writeM  <= 1'b0;
      result_srcM <= RES_ALU;
      rdW         <= '0;
      reg_writeW  <= 1'b0;
    end else begin
      rdM         <= rdE;
      reg_writeM  <= reg_writeE;
      result_srcM <= result_srcE;
      rdW         <= rdM;
      reg_writeW  <= reg_writeM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (result_srcM inside {RES_ALU, RES_LOAD, RES_PC4})
        else $error("reserved result source reached M");
    end
  end

  always_comb begin
    forward_aE = FWD_RF;
    forward_bE = FWD_RF;
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    lwStall    = (result_srcE == RES_LOAD) && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
    if (reset) begin
      if (reg_writeM && (rdM != '0) && (rdM == rs1E)) begin
        forward_aE = FWD_M;
      end else if (reg_writeW && (rdW != '0) && (rdW == rs1E)) begin
        forward_aE = FWD_W;
      end
      if (reg_writeM && (rdM != '0) && (rdM == rs2E)) begin
        forward_bE = FWD_M;
      end else if (reg_writeW && (rdW != '0) && (rdW == rs2E)) begin
        forward_bE = FWD_W;
      end
      // A taken redirect squashes Decode, so a coincident load-use must not stall.
      stallF = lwStall && !pc_srcE;
      stallD = lwStall && !pc_srcE;
      flushD = pc_srcE;
      flushE = lwStall || pc_srcE;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallD),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushD),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed self-checking bench for hazard_tracker
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
  logic       reg_writeE, pc_srcE;
  logic [1:0] result_srcE;

  logic [1:0]  forward_aE, forward_bE;
  logic        stallF, stallD, flushD, flushE;
  logic [4:0]  rdM, rdW;
  logic        reg_writeM, reg_writeW;
  logic [31:0] stall_cnt, flush_cnt;

  logic [1:0]  fa4, fb4;
  logic        sf4, sd4, fd4, fe4;
  logic [4:0]  rdM4, rdW4;
  logic        rwM4, rwW4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .reg_writeE(reg_writeE), .result_srcE(result_srcE), .pc_srcE(pc_srcE),
    .forward_aE(forward_aE), .forward_bE(forward_bE), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .rdM(rdM), .reg_writeM(reg_writeM), .rdW(rdW),
    .reg_writeW(reg_writeW), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_tracker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .reg_writeE(reg_writeE), .result_srcE(result_srcE), .pc_srcE(pc_srcE),
    .forward_aE(fa4), .forward_bE(fb4), .stallF(sf4), .stallD(sd4),
    .flushD(fd4), .flushE(fe4), .rdM(rdM4), .reg_writeM(rwM4), .rdW(rdW4),
    .reg_writeW(rwW4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setE(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic we, input logic [1:0] src);
    rs1E = a; rs2E = b; rdE = d; reg_writeE = we; result_srcE = src;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rs1D = 5'd5; rs2D = 5'd0; pc_srcE = 1'b1;
    setE(5'd5, 5'd5, 5'd5, 1'b1, 2'b01);
    tick();
    cmp++; if (rdM !== 5'd0) begin bad++; $display("FAIL reset_rdM: got %0d expected 0", rdM); end
    cmp++; if (reg_writeM !== 1'b0 || reg_writeW !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b%0b expected 00", reg_writeM, reg_writeW); end
    cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    cmp++; if ({forward_aE, forward_bE, stallF, stallD, flushD, flushE} !== 8'h00) begin bad++; $display("FAIL reset_outs: got %0h expected 0", {forward_aE, forward_bE, stallF, stallD, flushD, flushE}); end
    pc_srcE = 1'b0; rs1D = 5'd0;
    setE(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    rs1D = 5'd5; rs2D = 5'd1;
    setE(5'd1, 5'd2, 5'd5, 1'b1, 2'b00);
    tick();
    setE(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
    cmp++; if (forward_aE !== 2'b10 || forward_bE !== 2'b00) begin bad++; $display("FAIL b2b_fwd: got %b/%b expected 10/00", forward_aE, forward_bE); end
    cmp++; if (stallD !== 1'b0 || stallF !== 1'b0 || flushE !== 1'b0) begin bad++; $display("FAIL b2b_stall: got %b%b%b expected 000", stallF, stallD, flushE); end
    cmp++; if (rdM !== 5'd5 || reg_writeM !== 1'b1) begin bad++; $display("FAIL b2b_shadowM: got %0d/%b expected 5/1", rdM, reg_writeM); end
    rs1D = 5'd0; rs2D = 5'd0;
  endtask

  task automatic test_distance2();
    tick();
    setE(5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    tick();
    setE(5'd0, 5'd0, 5'd8, 1'b1, 2'b00);
    tick();
    setE(5'd0, 5'd7, 5'd9, 1'b1, 2'b00);
    cmp++; if (forward_bE !== 2'b01) begin bad++; $display("FAIL dist2_fwdW: got %b expected 01", forward_bE); end
    cmp++; if (rdW !== 5'd7 || reg_writeW !== 1'b1) begin bad++; $display("FAIL dist2_shadowW: got %0d/%b expected 7/1", rdW, reg_writeW); end
    setE(5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    tick();
    setE(5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    tick();
    setE(5'd0, 5'd7, 5'd0, 1'b0, 2'b00);
    cmp++; if (forward_bE !== 2'b10) begin bad++; $display("FAIL dist2_Mprio: got %b expected 10", forward_bE); end
  endtask

  task automatic test_x0_guard();
    setE(5'd0, 5'd0, 5'd0, 1'b1, 2'b00);
    tick();
    setE(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    cmp++; if (reg_writeM !== 1'b1 || rdM !== 5'd0) begin bad++; $display("FAIL x0_shadow: got %0d/%b expected 0/1", rdM, reg_writeM); end
    cmp++; if (forward_aE !== 2'b00 || forward_bE !== 2'b00) begin bad++; $display("FAIL x0_fwd: got %b/%b expected 00/00", forward_aE, forward_bE); end
  endtask

  task automatic test_load_use();
    rs1D = 5'd4; rs2D = 5'd3; pc_srcE = 1'b0;
    setE(5'd0, 5'd0, 5'd3, 1'b1, 2'b01);
    cmp++; if ({stallF, stallD, flushD, flushE} !== 4'b1101) begin bad++; $display("FAIL lu_ctrl: got %b expected 1101", {stallF, stallD, flushD, flushE}); end
    tick();
    setE(5'd0, 5'd3, 5'd0, 1'b0, 2'b00);
    cmp++; if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin bad++; $display("FAIL lu_bubble_ctrl: got %b expected 0000", {stallF, stallD, flushD, flushE}); end
    cmp++; if (forward_bE !== 2'b10) begin bad++; $display("FAIL lu_bubble_fwd: got %b expected 10", forward_bE); end
    cmp++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
    rs1D = 5'd0; rs2D = 5'd0;
    setE(5'd0, 5'd3, 5'd11, 1'b1, 2'b00);
    cmp++; if (forward_bE !== 2'b01) begin bad++; $display("FAIL lu_dep_fwdW: got %b expected 01", forward_bE); end
    cmp++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_hold: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_branch_loaduse();
    rs1D = 5'd4; pc_srcE = 1'b1;
    setE(5'd0, 5'd0, 5'd4, 1'b1, 2'b01);
    cmp++; if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin bad++; $display("FAIL br_ctrl: got %b expected 0011", {stallF, stallD, flushD, flushE}); end
    tick();
    pc_srcE = 1'b0; rs1D = 5'd0;
    setE(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    cmp++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin bad++; $display("FAIL br_cnt: got %0d/%0d expected 1/1", flush_cnt, stall_cnt); end
    cmp++; if (flush_cnt4 !== 4'd1) begin bad++; $display("FAIL br_cnt4: got %0d expected 1", flush_cnt4); end
  endtask

  task automatic test_reset_midstream();
    setE(5'd0, 5'd0, 5'd10, 1'b1, 2'b00);
    tick();
    cmp++; if (reg_writeM !== 1'b1 || rdM !== 5'd10) begin bad++; $display("FAIL mid_pre: got %0d/%b expected 10/1", rdM, reg_writeM); end
    reset = 1'b0;
    rs1D = 5'd3; pc_srcE = 1'b1;
    setE(5'd10, 5'd10, 5'd3, 1'b1, 2'b01);
    cmp++; if ({forward_aE, forward_bE, stallF, stallD, flushD, flushE} !== 8'h00) begin bad++; $display("FAIL mid_outs: got %0h expected 0", {forward_aE, forward_bE, stallF, stallD, flushD, flushE}); end
    tick();
    cmp++; if (rdM !== 5'd0 || reg_writeM !== 1'b0 || rdW !== 5'd0 || reg_writeW !== 1'b0) begin bad++; $display("FAIL mid_shadow: got %0d/%b/%0d/%b expected 0/0/0/0", rdM, reg_writeM, rdW, reg_writeW); end
    cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, stall_cnt4); end
    reset = 1'b1;
    rs1D = 5'd0; pc_srcE = 1'b0;
    setE(5'd10, 5'd10, 5'd0, 1'b0, 2'b00);
    cmp++; if (forward_aE !== 2'b00 || forward_bE !== 2'b00) begin bad++; $display("FAIL mid_release_fwd: got %b/%b expected 00/00", forward_aE, forward_bE); end
    tick();
  endtask

  task automatic test_saturation();
    rs1D = 5'd3; pc_srcE = 1'b0;
    setE(5'd0, 5'd0, 5'd3, 1'b1, 2'b01);
    for (int i = 0; i < 20; i++) tick();
    cmp++; if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4: got %0d expected 15", stall_cnt4); end
    cmp++; if (stall_cnt !== 32'd20) begin bad++; $display("FAIL sat_cnt32: got %0d expected 20", stall_cnt); end
    rs1D = 5'd0;
    setE(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
  endtask

  initial begin
    rs1D = '0; rs2D = '0; pc_srcE = 1'b0;
    setE(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    test_reset();
    test_back_to_back();
    test_distance2();
    test_x0_guard();
    test_load_use();
    test_branch_loaduse();
    test_reset_midstream();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Execute-side consumer of the decode/execute pipeline register outputs: rs1E, rs2E, rdE, reg_writeE, result_srcE.
- Keeps its own registered M and W shadow copies of destination register, register-write enable and result source, so it needs no EM/MW pipe taps.
- From these it produces ALU operand forwarding selects, load-use stall, branch/jump flush controls and saturating hazard performance counters for the 5-stage RV32I pipeline.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low reset: clears state when sampled 0 at posedge clk.
- rs1D  in  REG_AW  source register 1 of the instruction in Decode.
- rs2D  in  REG_AW  source register 2 of the instruction in Decode.
- rs1E  in  REG_AW  source register 1 in Execute.
- rs2E  in  REG_AW  source register 2 in Execute.
- rdE  in  REG_AW  destination register in Execute.
- reg_writeE  in  1  Execute instruction writes the register file.
- result_srcE  in  2  Execute result source: 00 ALU, 01 load, 10 pc+4.
- pc_srcE  in  1  branch taken, jal or jalr resolved in Execute.
- forward_aE  out  2  operand A select: 00 register file, 10 M ALU result, 01 W result.
- forward_bE  out  2  operand B select, same encoding.
- stallF  out  1  hold the PC.
- stallD  out  1  hold the F/D register.
- flushD  out  1  clear the F/D register.
- flushE  out  1  clear the D/E register (insert bubble).
- rdM  out  REG_AW  shadow M destination.
- reg_writeM  out  1  shadow M write enable.
- rdW  out  REG_AW  shadow W destination.
- reg_writeW  out  1  shadow W write enable.
- stall_cnt  out  CNT_W  cycles with stallD=1.
- flush_cnt  out  CNT_W  cycles with pc_srcE=1.

Behaviour:
- Reset (reset=0 at posedge): rdM, rdW, reg_writeM, reg_writeW, result_srcM, stall_cnt and flush_cnt all go to 0.
- While reset is low, all combinational outputs are forced to 0: forward_*E=00, stall*=0, flush*=0.
- Shadow pipeline, one register per stage, advancing every cycle with no enable:
  - M <= E: rdM<=rdE, reg_writeM<=reg_writeE, result_srcM<=result_srcE.
  - W <= M.
  - Execute always advances. A flushE bubble arrives on the E inputs as reg_writeE=0, so it propagates naturally.
- Forwarding (combinational on E inputs and registered M/W), per operand X in {rs1E, rs2E}:
  - 10 if reg_writeM, rdM!=0 and rdM==X.
  - Else 01 if reg_writeW, rdW!=0 and rdW==X.
  - Else 00.
  - M has priority over W when both match.
- Load-use hazard: lwStall = (result_srcE==01) and rdE!=0 and (rdE==rs1D or rdE==rs2D).
  - reg_writeE is not required, so a load-typed bubble never occurs because bubbles carry result_srcE=00.
- Control outputs (combinational, zero latency):
  - stallF = stallD = lwStall and not pc_srcE.
  - flushD = pc_srcE.
  - flushE = lwStall or pc_srcE.
  - When lwStall and pc_srcE coincide, the flush wins: no stall, both flushes asserted, because the Decode instruction is squashed.
- Counters, registered and updated each cycle reset=1:
  - stall_cnt += 1 when stallD=1.
  - flush_cnt += 1 when pc_srcE=1.
  - Both saturate at all-ones; no wrap.
- Latency:
  - Forward selects and control outputs respond in the same cycle.
  - Shadow M reflects E one cycle later; W reflects E two cycles later.
  - Counters show an event one cycle after it.
- Reset mid-operation: shadow state clears in that cycle. The first cycle after release forwards nothing from M/W.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - result_src encodings RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10.
  - forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - REG_AW.
- One natural sub-module: sat_counter (CNT_W param, inc, synchronous active-low clear), instantiated twice.

Test Plan:
- Back-to-back ALU: add x5 in E, next cycle sub uses x5 as rs1E -> forward_aE=10, forward_bE=00, no stall.
- Distance-2: x7 written by the instruction two ahead, rs2E=7 -> forward_bE=01; when both M and W hold rd=7, forward_bE=10.
- x0 guard: reg_writeM=1, rdM=0, rs1E=0 -> forward_aE=00.
- Load-use: result_srcE=01, rdE=3, rs2D=3 -> stallF=stallD=flushE=1, flushD=0. One cycle later, with the bubble in E, all clear and forward_bE=10 from M. stall_cnt reads 1.
- Branch taken with simultaneous load-use (pc_srcE=1, lwStall true) -> flushD=flushE=1, stallF=stallD=0. flush_cnt increments and stall_cnt is unchanged.
- Reset=0 for one cycle mid-stream with reg_writeM=1 -> next cycle rdM=0, reg_writeM=0, counters 0, all outputs 0 during the reset cycle. Counter saturation is checked with CNT_W=4 and 20 stall cycles -> stall_cnt=15.
